tile_icon_mapper: RTL and testbench

Parametrised successor to the fixed-position image selector in the VGA overlay path. Maps the current tile column/row (Qh, upper bits of Qv) to an icon-ROM address {icon id, line within tile}. Uses NUM_SLOTS runtime-configurable icon slots instead of hard-wired positions. Adds per-slot enable and blink, tear-free frame-boundary config commit, fixed priority and a registered 2-cycle pipeline. It sits between the VGA tile counters and the icon ROM.

---
 rtl/tile_icon_mapper_if.sv | 12 +
 rtl/tile_icon_mapper.sv | 128 ++++++++++++
 tb/tb_tile_icon_mapper.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_icon_mapper_if.sv
// Slot-configuration write bus for tile_icon_mapper: strobe, slot index, payload and accept pulse.
interface tile_icon_mapper_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic              cfg_we;
  logic [3:0]        cfg_slot;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_ack;

  modport master (output cfg_we, output cfg_slot, output cfg_data, input  cfg_ack);
  modport slave  (input  cfg_we, input  cfg_slot, input  cfg_data, output cfg_ack);
endinterface

// File: rtl/tile_icon_mapper.sv
// Tile-to-icon address mapper: configurable icon slots with shadow/active
// registers committed at frame start, per-slot blink, fixed lowest-index
// priority and a two-stage registered lookup pipeline.
module tile_icon_mapper #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned TILE_W    = 5,
  parameter int unsigned ROW_W     = 5,
  parameter int unsigned BLINK_DIV = 30
) (
  input  logic                     reloj,
  input  logic                     resetM,
  input  logic [TILE_W-1:0]        Qh,
  input  logic [TILE_W+ROW_W-1:0]  Qv,
  input  logic                     frame_start,
  tile_icon_mapper_if.slave        cfg,
  output logic [ID_W+ROW_W-1:0]    DIR_IM,
  output logic                     dir_valid,
  output logic [3:0]               hit_slot
);

  localparam int unsigned CFG_W  = 2 + ID_W + 2 * TILE_W;
  localparam int unsigned V_LSB  = TILE_W;
  localparam int unsigned ID_LSB = 2 * TILE_W;
  localparam int unsigned BL_BIT = 2 * TILE_W + ID_W;
  localparam int unsigned EN_BIT = BL_BIT + 1;
  localparam int unsigned CNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CFG_W-1:0]       r_shadow [NUM_SLOTS];
  logic [CFG_W-1:0]       r_active [NUM_SLOTS];
  logic                   r_cfg_ack;
  logic [CNT_W-1:0]       r_blink_cnt;
  logic                   r_blink_phase;
  logic [TILE_W-1:0]      r_h;
  logic [TILE_W-1:0]      r_v;
  logic [ROW_W-1:0]       r_line;
  logic [ID_W+ROW_W-1:0]  r_dir_im;
  logic                   r_dir_valid;
  logic [3:0]             r_hit_slot;

  logic                   w_cfg_ok;
  logic                   w_hit;
  logic [3:0]             w_idx;
  logic [ID_W-1:0]        w_id;

  assign w_cfg_ok    = cfg.cfg_we && (32'(cfg.cfg_slot) < NUM_SLOTS);
  assign cfg.cfg_ack = r_cfg_ack;
  assign DIR_IM      = r_dir_im;
  assign dir_valid   = r_dir_valid;
  assign hit_slot    = r_hit_slot;

  // Shadow writes every cycle; active set copies old shadow only at frame start.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_cfg_ack <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        if (w_cfg_ok && (cfg.cfg_slot == 4'(i))) r_shadow[i] <= cfg.cfg_data;
        if (frame_start)                         r_active[i] <= r_shadow[i];
      end
      r_cfg_ack <= w_cfg_ok;
    end
  end

  // Frame counter wraps at BLINK_DIV-1 and toggles the blink phase.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (r_blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + CNT_W'(1);
      end
    end
  end

  // Stage 1: split the tile coordinates.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      r_h    <= '0;
      r_v    <= '0;
      r_line <= '0;
    end else begin
      r_h    <= Qh;
      r_v    <= Qv[TILE_W+ROW_W-1:ROW_W];
      r_line <= Qv[ROW_W-1:0];
    end
  end

  // Slot match with lowest index winning (scan high to low, last match kept).
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    w_id  = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (r_active[i][EN_BIT]
          && (r_active[i][ID_LSB +: ID_W] != '0)
          && (r_active[i][V_LSB +: TILE_W] == r_v)
          && (r_active[i][TILE_W-1:0] == r_h)
          && (!r_active[i][BL_BIT] || r_blink_phase)) begin
        w_hit = 1'b1;
        w_idx = 4'(i);
        w_id  = r_active[i][ID_LSB +: ID_W];
      end
    end
  end

  // Stage 2: registered ROM address and hit information.
  always_ff @(posedge reloj) begin
    if (resetM) begin
      r_dir_im    <= '0;
      r_dir_valid <= 1'b0;
      r_hit_slot  <= '0;
    end else begin
      r_dir_im    <= w_hit ? {w_id, r_line} : '0;
      r_dir_valid <= w_hit;
      r_hit_slot  <= w_idx;
    end
  end

endmodule

// File: tb/tb_tile_icon_mapper.sv
// Directed testbench for tile_icon_mapper (NUM_SLOTS=8, ID_W=4, TILE_W=5, ROW_W=5, BLINK_DIV=2).
module tb_tile_icon_mapper;

  localparam int unsigned CFG_W = 16;

  logic       reloj;
  logic       resetM;
  logic [4:0] Qh;
  logic [9:0] Qv;
  logic       frame_start;
  logic [8:0] DIR_IM;
  logic       dir_valid;
  logic [3:0] hit_slot;

  int passed;
  int total;

  tile_icon_mapper_if #(.DATA_W(CFG_W)) cfg_if ();

  tile_icon_mapper #(
    .NUM_SLOTS(8), .ID_W(4), .TILE_W(5), .ROW_W(5), .BLINK_DIV(2)
  ) dut (
    .reloj(reloj), .resetM(resetM), .Qh(Qh), .Qv(Qv), .frame_start(frame_start),
    .cfg(cfg_if), .DIR_IM(DIR_IM), .dir_valid(dir_valid), .hit_slot(hit_slot)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  function automatic logic [15:0] mk(input logic en, input logic bl, input logic [3:0] id,
                                     input logic [4:0] v, input logic [4:0] h);
    return {en, bl, id, v, h};
  endfunction

  task automatic do_reset();
    @(negedge reloj);
    resetM = 1'b1; frame_start = 1'b0; Qh = '0; Qv = '0;
    cfg_if.cfg_we = 1'b0; cfg_if.cfg_slot = '0; cfg_if.cfg_data = '0;
    @(negedge reloj);
    @(negedge reloj);
    resetM = 1'b0;
  endtask

  // Single write cycle; returns cfg_ack as seen one edge later.
  task automatic cfg_write(input logic [3:0] slot, input logic [15:0] data, output logic ack);
    @(negedge reloj);
    cfg_if.cfg_we = 1'b1; cfg_if.cfg_slot = slot; cfg_if.cfg_data = data;
    @(posedge reloj); #1;
    ack = cfg_if.cfg_ack;
    @(negedge reloj);
    cfg_if.cfg_we = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge reloj); frame_start = 1'b1;
    @(negedge reloj); frame_start = 1'b0;
  endtask

  task automatic lookup(input logic [4:0] h, input logic [9:0] v);
    @(negedge reloj);
    Qh = h; Qv = v;
    @(posedge reloj);
    @(posedge reloj); #1;
  endtask

  task automatic test_reset();
    int bad;
    int acks;
    bad = 0; acks = 0;
    do_reset();
    total++;
    if (DIR_IM !== 9'h000 || dir_valid !== 1'b0 || hit_slot !== 4'd0 || cfg_if.cfg_ack !== 1'b0)
      $display("FAIL reset_outputs: DIR_IM=%h valid=%b hit=%0d ack=%b, want all 0", DIR_IM, dir_valid, hit_slot, cfg_if.cfg_ack);
    else passed++;
    for (int v = 0; v < 32; v++) begin
      if (v % 8 == 0) begin
        @(negedge reloj); frame_start = 1'b1;
      end
      for (int h = 0; h < 32; h++) begin
        @(negedge reloj);
        if (h != 0) frame_start = 1'b0;
        Qh = 5'(h); Qv = {5'(v), 5'(h ^ v)};
        if (dir_valid !== 1'b0 || DIR_IM !== 9'h000) bad++;
        if (cfg_if.cfg_ack !== 1'b0) acks++;
      end
    end
    frame_start = 1'b0;
    total++;
    if (bad != 0) $display("FAIL reset_sweep: %0d cycles with a hit, want 0", bad);
    else passed++;
    total++;
    if (acks != 0) $display("FAIL reset_sweep_ack: %0d acks, want 0", acks);
    else passed++;
  endtask

  task automatic test_basic();
    logic ack;
    do_reset();
    cfg_write(4'd2, mk(1'b1, 1'b0, 4'd3, 5'd3, 5'd4), ack);
    total++;
    if (ack !== 1'b1) $display("FAIL basic_ack: got %b want 1", ack);
    else passed++;
    @(negedge reloj);
    total++;
    if (cfg_if.cfg_ack !== 1'b0) $display("FAIL basic_ack_pulse: got %b want 0", cfg_if.cfg_ack);
    else passed++;
    lookup(5'd4, {5'd3, 5'd17});
    total++;
    if (dir_valid !== 1'b0) $display("FAIL basic_precommit: valid=%b want 0", dir_valid);
    else passed++;
    pulse_frame();
    lookup(5'd4, {5'd3, 5'd17});
    total++;
    if (DIR_IM !== 9'h071 || dir_valid !== 1'b1 || hit_slot !== 4'd2)
      $display("FAIL basic_hit: DIR_IM=%h valid=%b hit=%0d want 071 1 2", DIR_IM, dir_valid, hit_slot);
    else passed++;
    lookup(5'd5, {5'd3, 5'd17});
    total++;
    if (DIR_IM !== 9'h000 || dir_valid !== 1'b0 || hit_slot !== 4'd0)
      $display("FAIL basic_miss_h: DIR_IM=%h valid=%b hit=%0d want 000 0 0", DIR_IM, dir_valid, hit_slot);
    else passed++;
    lookup(5'd4, {5'd4, 5'd17});
    total++;
    if (dir_valid !== 1'b0) $display("FAIL basic_miss_v: valid=%b want 0", dir_valid);
    else passed++;
  endtask

  // Per-cycle lookups; output follows input by two edges. Slot 2 still holds (h=4,v=3,id=3).
  task automatic test_back_to_back();
    logic [4:0] hs [4];
    logic [9:0] vs [4];
    logic [8:0] exp_dir [4];
    logic       exp_val [4];
    hs[0] = 5'd4; vs[0] = {5'd3, 5'd1};  exp_dir[0] = 9'h061; exp_val[0] = 1'b1;
    hs[1] = 5'd0; vs[1] = {5'd3, 5'd1};  exp_dir[1] = 9'h000; exp_val[1] = 1'b0;
    hs[2] = 5'd4; vs[2] = {5'd3, 5'd31}; exp_dir[2] = 9'h07f; exp_val[2] = 1'b1;
    hs[3] = 5'd4; vs[3] = {5'd2, 5'd31}; exp_dir[3] = 9'h000; exp_val[3] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge reloj);
      if (k < 4) begin Qh = hs[k]; Qv = vs[k]; end
      @(posedge reloj); #1;
      if (k >= 1) begin
        total++;
        if (DIR_IM !== exp_dir[k-1] || dir_valid !== exp_val[k-1])
          $display("FAIL b2b_%0d: DIR_IM=%h valid=%b want %h %b", k-1, DIR_IM, dir_valid, exp_dir[k-1], exp_val[k-1]);
        else passed++;
      end
    end
  endtask

  task automatic test_priority();
    logic ack;
    do_reset();
    cfg_write(4'd5, mk(1'b1, 1'b0, 4'd6, 5'd3, 5'd18), ack);
    cfg_write(4'd1, mk(1'b1, 1'b0, 4'd2, 5'd3, 5'd18), ack);
    pulse_frame();
    lookup(5'd18, {5'd3, 5'd7});
    total++;
    if (DIR_IM !== 9'h047 || dir_valid !== 1'b1 || hit_slot !== 4'd1)
      $display("FAIL prio_low_wins: DIR_IM=%h valid=%b hit=%0d want 047 1 1", DIR_IM, dir_valid, hit_slot);
    else passed++;
    cfg_write(4'd1, mk(1'b0, 1'b0, 4'd2, 5'd3, 5'd18), ack);
    lookup(5'd18, {5'd3, 5'd7});
    total++;
    if (hit_slot !== 4'd1) $display("FAIL prio_no_midframe_change: hit=%0d want 1", hit_slot);
    else passed++;
    pulse_frame();
    lookup(5'd18, {5'd3, 5'd7});
    total++;
    if (DIR_IM !== 9'h0c7 || dir_valid !== 1'b1 || hit_slot !== 4'd5)
      $display("FAIL prio_disabled: DIR_IM=%h valid=%b hit=%0d want 0c7 1 5", DIR_IM, dir_valid, hit_slot);
    else passed++;
    cfg_write(4'd5, mk(1'b1, 1'b0, 4'd0, 5'd3, 5'd18), ack);
    pulse_frame();
    lookup(5'd18, {5'd3, 5'd7});
    total++;
    if (dir_valid !== 1'b0 || DIR_IM !== 9'h000) $display("FAIL prio_id0_blank: DIR_IM=%h valid=%b want 000 0", DIR_IM, dir_valid);
    else passed++;
  endtask

  task automatic test_blink();
    logic ack;
    logic exp_shown [7];
    exp_shown = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    cfg_write(4'd0, mk(1'b1, 1'b1, 4'd5, 5'd2, 5'd2), ack);
    for (int f = 0; f < 7; f++) begin
      if (f > 0) pulse_frame();
      lookup(5'd2, {5'd2, 5'd0});
      total++;
      if (dir_valid !== exp_shown[f] || DIR_IM !== (exp_shown[f] ? 9'h0a0 : 9'h000))
        $display("FAIL blink_frame%0d: valid=%b DIR_IM=%h want %b", f, dir_valid, DIR_IM, exp_shown[f]);
      else passed++;
    end
  endtask

  task automatic test_frame_collide();
    logic ack;
    do_reset();
    cfg_write(4'd3, mk(1'b1, 1'b0, 4'd7, 5'd1, 5'd1), ack);
    pulse_frame();
    lookup(5'd1, {5'd1, 5'd4});
    total++;
    if (DIR_IM !== 9'h0e4 || hit_slot !== 4'd3) $display("FAIL collide_initial: DIR_IM=%h hit=%0d want 0e4 3", DIR_IM, hit_slot);
    else passed++;
    @(negedge reloj);
    cfg_if.cfg_we = 1'b1; cfg_if.cfg_slot = 4'd3; cfg_if.cfg_data = mk(1'b1, 1'b0, 4'd9, 5'd1, 5'd1);
    frame_start = 1'b1;
    @(negedge reloj);
    cfg_if.cfg_we = 1'b0; frame_start = 1'b0;
    lookup(5'd1, {5'd1, 5'd4});
    total++;
    if (DIR_IM !== 9'h0e4) $display("FAIL collide_old_kept: DIR_IM=%h want 0e4", DIR_IM);
    else passed++;
    pulse_frame();
    lookup(5'd1, {5'd1, 5'd4});
    total++;
    if (DIR_IM !== 9'h124 || hit_slot !== 4'd3) $display("FAIL collide_new_next: DIR_IM=%h hit=%0d want 124 3", DIR_IM, hit_slot);
    else passed++;
    cfg_write(4'd8, mk(1'b1, 1'b0, 4'd1, 5'd10, 5'd10), ack);
    total++;
    if (ack !== 1'b0) $display("FAIL oob_no_ack: got %b want 0", ack);
    else passed++;
    pulse_frame();
    lookup(5'd10, {5'd10, 5'd0});
    total++;
    if (dir_valid !== 1'b0) $display("FAIL oob_no_state: valid=%b hit=%0d want 0", dir_valid, hit_slot);
    else passed++;
    lookup(5'd1, {5'd1, 5'd4});
    total++;
    if (DIR_IM !== 9'h124 || hit_slot !== 4'd3) $display("FAIL oob_slot3_intact: DIR_IM=%h hit=%0d want 124 3", DIR_IM, hit_slot);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic ack;
    do_reset();
    cfg_write(4'd2, mk(1'b1, 1'b0, 4'd3, 5'd3, 5'd4), ack);
    pulse_frame();
    lookup(5'd4, {5'd3, 5'd17});
    total++;
    if (dir_valid !== 1'b1 || DIR_IM !== 9'h071) $display("FAIL rstmid_pre: DIR_IM=%h valid=%b want 071 1", DIR_IM, dir_valid);
    else passed++;
    @(negedge reloj);
    resetM = 1'b1;
    cfg_if.cfg_we = 1'b1; cfg_if.cfg_slot = 4'd4; cfg_if.cfg_data = mk(1'b1, 1'b0, 4'd1, 5'd3, 5'd4);
    @(posedge reloj); #1;
    total++;
    if (DIR_IM !== 9'h000 || dir_valid !== 1'b0 || hit_slot !== 4'd0 || cfg_if.cfg_ack !== 1'b0)
      $display("FAIL rstmid_outputs: DIR_IM=%h valid=%b hit=%0d ack=%b want 0", DIR_IM, dir_valid, hit_slot, cfg_if.cfg_ack);
    else passed++;
    @(negedge reloj);
    resetM = 1'b0; cfg_if.cfg_we = 1'b0;
    pulse_frame();
    lookup(5'd4, {5'd3, 5'd17});
    total++;
    if (dir_valid !== 1'b0 || hit_slot !== 4'd0) $display("FAIL rstmid_slots_cleared: valid=%b hit=%0d want 0 0", dir_valid, hit_slot);
    else passed++;
  endtask

  initial begin
    passed = 0; total = 0;
    resetM = 1'b1; frame_start = 1'b0; Qh = '0; Qv = '0;
    cfg_if.cfg_we = 1'b0; cfg_if.cfg_slot = '0; cfg_if.cfg_data = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_priority();
    test_blink();
    test_frame_collide();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
